fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent field width; only the default SHALL be required to work.
REQ-002 Parameter MANTISSA_WIDTH, default 23, fraction field width; only the default SHALL be required to work.
REQ-003 clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  operands a, b are valid this cycle.
REQ-006 in_ready  out  1  block can accept operands; SHALL equal (state == IDLE).
REQ-007 a  in  32  IEEE-754 single-precision dividend.
REQ-008 b  in  32  IEEE-754 single-precision divisor.
REQ-009 out_valid  out  1  result and flags are valid.
REQ-010 out_ready  in  1  consumer takes the result.
REQ-011 result  out  32  quotient a/b, registered.
REQ-012 overflow, underflow, inf, nan, div_by_zero  out  1 each  registered status flags, qualified by out_valid.

Function
REQ-013 FSM states SHALL be IDLE, DIV, NORM, DONE.
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 in IDLE; a, b SHALL be captured at that edge; in_valid outside IDLE SHALL be ignored.
REQ-015 Inputs with exponent 0 SHALL be treated as signed zero (subnormals flushed).
REQ-016 Sign SHALL be a[31] XOR b[31] for every non-NaN result.
REQ-017 Special cases decided at accept; FSM IDLE->DONE; out_valid SHALL rise 1 cycle after accept:
  - either NaN, 0/0, or inf/inf -> 0x7FC00000, nan=1;
  - inf/finite -> signed inf, inf=1;
  - nonzero finite/0 -> signed inf, inf=1, div_by_zero=1;
  - 0/nonzero, or finite/inf -> signed zero, all flags 0.
REQ-018 Normal case: IDLE->DIV; restoring radix-2 division of 24-bit significands (hidden 1 included), one quotient bit per cycle, 26 cycles (q[25] weight 2^0 down to q[0]).
REQ-019 Per DIV step: if rem >= divisor, qbit=1 and rem -= divisor, else qbit=0; then rem <<= 1; initial rem = dividend significand.
REQ-020 Biased exponent SHALL be ea - eb + 127, computed in a 10-bit signed width.
REQ-021 NORM: if q[25]=1, sig=q[25:2], guard=q[1], sticky=q[0]|(rem!=0); else sig=q[24:1], guard=q[0], sticky=(rem!=0), exponent -1.
REQ-022 Rounding SHALL be round-to-nearest-even: increment sig if guard & (sticky | sig[0]); carry out of 24 bits SHALL shift right and add 1 to exponent.
REQ-023 After rounding, exponent >= 255 -> signed inf, overflow=1, inf=1; exponent <= 0 -> signed zero, underflow=1.
REQ-024 Normal-case out_valid SHALL rise exactly MANTISSA_WIDTH+5 = 28 cycles after the accepting edge.
REQ-025 In DONE, result and flags SHALL hold stable while out_ready=0; out_valid & out_ready SHALL return FSM to IDLE on that edge.
REQ-026 in_ready SHALL be 0 in DONE; a new accept can occur no earlier than the cycle after the handshake (no same-cycle overlap).
REQ-027 Flags not explicitly set for a result SHALL be 0.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, out_valid=0, result=0, all flags 0, quotient/remainder/counter cleared, regardless of state.
REQ-029 rst asserted mid-DIV or in DONE SHALL abort the operation; no result from it SHALL ever appear.
REQ-030 rst SHALL take priority over in_valid and out_ready in the same cycle; in_ready SHALL be 1 the cycle after rst deasserts.

Verification
REQ-031 a=0x40C00000 (6.0), b=0x40000000 -> result 0x40400000, flags 0, out_valid exactly 28 cycles after accept.
REQ-032 a=0x3F800000, b=0x40400000 (1/3) -> 0x3EAAAAAB (round-up path exercised), flags 0.
REQ-033 a=0x3F800000, b=0x00000000 -> 0x7F800000, inf=1, div_by_zero=1, 1-cycle latency; a=0, b=0 -> 0x7FC00000, nan=1.
REQ-034 a=0x7F000000, b=0x00800000 -> 0x7F800000, overflow=1, inf=1; a=0x00800000, b=0x7F000000 -> 0x00000000, underflow=1.
REQ-035 Hold out_ready=0 for 10 cycles after out_valid -> result/flags unchanged, in_ready=0; release -> IDLE next cycle, back-to-back accept works.
REQ-036 Assert rst for one cycle at DIV step 10 -> out_valid stays 0, in_ready=1 next cycle, following 6.0/2.0 gives 0x40400000 at 28 cycles.

Source files
------------

// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for fp_divider: a valid/ready request channel
// carrying the operands and a valid/ready response channel carrying the quotient and flags.
interface fp_divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inf;
  logic        nan;
  logic        div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inf, nan, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inf, nan, div_by_zero
  );
endinterface

// File: rtl/fp_divider.sv
// Iterative single-precision divider: restoring radix-2 significand division, one quotient
// bit per cycle, round-to-nearest-even, subnormal inputs and outputs flushed to zero.
module fp_divider #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23
) (
  input logic         clk,
  input logic         rst,
  fp_divider_if.slave bus
);
  localparam int unsigned SigW = MANTISSA_WIDTH + 1;
  localparam int unsigned QW   = MANTISSA_WIDTH + 3;
  localparam int unsigned RemW = SigW + 2;
  localparam int unsigned EW   = EXP_WIDTH + 2;
  localparam int unsigned CntW = $clog2(QW);
  localparam logic [CntW-1:0]       LastStep = CntW'(QW - 1);
  localparam logic [EXP_WIDTH-1:0]  ExpMax   = '1;
  localparam logic signed [EW-1:0]  Bias     = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic [31:0]           QNan     = {1'b0, ExpMax, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

  state_e                    state_q;
  logic [SigW-1:0]           div_q;
  logic [RemW-1:0]           rem_q;
  logic [QW-1:0]             quo_q;
  logic [CntW-1:0]           cnt_q;
  logic signed [EW-1:0]      exp_q;
  logic                      sign_q;
  logic                      out_valid_q;
  logic [31:0]               result_q;
  logic                      ovf_q, unf_q, inf_q, nan_q, dbz_q;

  // Operand decode, only meaningful in the accepting cycle
  logic [EXP_WIDTH-1:0]      ea, eb;
  logic [MANTISSA_WIDTH-1:0] fa, fb;
  logic                      a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;

  assign ea      = bus.a[MANTISSA_WIDTH +: EXP_WIDTH];
  assign eb      = bus.b[MANTISSA_WIDTH +: EXP_WIDTH];
  assign fa      = bus.a[MANTISSA_WIDTH-1:0];
  assign fb      = bus.b[MANTISSA_WIDTH-1:0];
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (ea == ExpMax) && (fa == '0);
  assign b_inf   = (eb == ExpMax) && (fb == '0);
  assign a_nan   = (ea == ExpMax) && (fa != '0);
  assign b_nan   = (eb == ExpMax) && (fb != '0);
  assign sign_in = bus.a[31] ^ bus.b[31];

  logic        spec_hit, spec_inf, spec_nan, spec_dbz;
  logic [31:0] spec_res;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_inf = 1'b0;
    spec_nan = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNan;
      spec_nan = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, ExpMax, {MANTISSA_WIDTH{1'b0}}};
      spec_inf = 1'b1;
    end else if (b_zero) begin
      spec_res = {sign_in, ExpMax, {MANTISSA_WIDTH{1'b0}}};
      spec_inf = 1'b1;
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {sign_in, {(EXP_WIDTH + MANTISSA_WIDTH){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic            rem_ge;
  logic [RemW-1:0] rem_sub;

  assign rem_ge  = rem_q >= {2'b00, div_q};
  assign rem_sub = rem_ge ? rem_q - {2'b00, div_q} : rem_q;

  // Normalise the 26-bit quotient to 1.23 form, then round to nearest even
  logic [SigW-1:0]      sig_pre;
  logic [SigW:0]        sig_rnd;
  logic                 guard, sticky;
  logic signed [EW-1:0] exp_pre, exp_rnd;
  logic                 norm_ovf, norm_unf;
  logic [31:0]          norm_res;

  always_comb begin
    if (quo_q[QW-1]) begin
      sig_pre = quo_q[QW-1:2];
      guard   = quo_q[1];
      sticky  = quo_q[0] | (|rem_q);
      exp_pre = exp_q;
    end else begin
      sig_pre = quo_q[QW-2:1];
      guard   = quo_q[0];
      sticky  = |rem_q;
      exp_pre = exp_q - EW'(1);
    end
    sig_rnd = {1'b0, sig_pre} + {{SigW{1'b0}}, guard & (sticky | sig_pre[0])};
    exp_rnd = exp_pre;
    if (sig_rnd[SigW]) begin
      sig_rnd = sig_rnd >> 1;
      exp_rnd = exp_pre + EW'(1);
    end
  end

  assign norm_unf = exp_rnd[EW-1] || (exp_rnd == '0);
  assign norm_ovf = !norm_unf && (exp_rnd[EW-2:0] >= {1'b0, ExpMax});
  assign norm_res = norm_ovf ? {sign_q, ExpMax, {MANTISSA_WIDTH{1'b0}}} :
                    norm_unf ? {sign_q, {(EXP_WIDTH + MANTISSA_WIDTH){1'b0}}} :
                               {sign_q, exp_rnd[EXP_WIDTH-1:0], sig_rnd[MANTISSA_WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      {ovf_q, unf_q, inf_q, nan_q, dbz_q} <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            sign_q <= sign_in;
            if (spec_hit) begin
              result_q <= spec_res;
              {ovf_q, unf_q, inf_q, nan_q, dbz_q} <= {2'b00, spec_inf, spec_nan, spec_dbz};
              state_q  <= StDone;
            end else begin
              div_q   <= {1'b1, fb};
              rem_q   <= {2'b00, 1'b1, fa};
              quo_q   <= '0;
              cnt_q   <= '0;
              exp_q   <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + Bias;
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          rem_q <= rem_sub << 1;
          quo_q <= {quo_q[QW-2:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastStep) state_q <= StNorm;
        end
        StNorm: begin
          result_q <= norm_res;
          {ovf_q, unf_q, inf_q, nan_q, dbz_q} <= {norm_ovf, norm_unf, norm_ovf, 2'b00};
          state_q  <= StDone;
        end
        StDone: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.inf         = inf_q;
  assign bus.nan         = nan_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vector table, hold/reset sequences and
// random operands checked against an integer-arithmetic reference model.
module tb_fp_divider;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_divider_if bus ();

  fp_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  string ctx      = "";

  // flag vector order: {overflow, underflow, inf, nan, div_by_zero}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %h, expected %h", name, ctx, act, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {bus.overflow, bus.underflow, bus.inf, bus.nan, bus.div_by_zero};
  endfunction

  // Reference: exact integer quotient of the significands, then RNE on the true remainder
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [4:0] flg,
                                output int lat);
    logic            s, an, bn, az, bz, ai, bi, g, st;
    int              ea, eb, e;
    longint unsigned ma, mb, num, q, r, sig;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    an  = (ea == 255) && (a[22:0] != 0);
    bn  = (eb == 255) && (b[22:0] != 0);
    ai  = (ea == 255) && (a[22:0] == 0);
    bi  = (eb == 255) && (b[22:0] == 0);
    az  = (ea == 0);
    bz  = (eb == 0);
    flg = 5'b00000;
    lat = 1;
    if (an || bn || (az && bz) || (ai && bi)) begin
      res = 32'h7FC0_0000;
      flg = 5'b00010;
    end else if (ai) begin
      res = {s, 8'hFF, 23'd0};
      flg = 5'b00100;
    end else if (bz) begin
      res = {s, 8'hFF, 23'd0};
      flg = 5'b00101;
    end else if (az || bi) begin
      res = {s, 31'd0};
    end else begin
      lat = 28;
      ma  = {40'd0, 1'b1, a[22:0]};
      mb  = {40'd0, 1'b1, b[22:0]};
      num = ma << 25;
      q   = num / mb;
      r   = num % mb;
      e   = ea - eb + 127;
      if (q >= (64'd1 << 25)) begin
        sig = q >> 2;
        g   = q[1];
        st  = q[0] || (r != 0);
      end else begin
        sig = q >> 1;
        g   = q[0];
        st  = (r != 0);
        e   = e - 1;
      end
      if (g && (st || sig[0])) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin
        sig = sig >> 1;
        e   = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0};
        flg = 5'b10100;
      end else if (e <= 0) begin
        res = {s, 31'd0};
        flg = 5'b01000;
      end else begin
        res = {s, e[7:0], sig[22:0]};
      end
    end
  endfunction

  // Call right after the accepting edge; counts edges until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 1;
    @(posedge clk); #1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic [4:0] ef, input int elat, input int hold, input string nm);
    int lat;
    ctx = $sformatf("%s a=%h b=%h", nm, a, b);
    check("in_ready_before", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    wait_valid(lat);
    check("latency", lat, elat);
    check("result", bus.result, er);
    check("flags", 32'(dut_flags()), 32'(ef));
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:23] = 8'h00;
      1:       v[30:23] = 8'hFF;
      2:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3:       v[30:23] = 8'(32'($urandom_range(1, 8)));
      4:       v[30:23] = 8'(32'($urandom_range(247, 254)));
      5:       v[22:0] = 23'd0;
      default: if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) v[30:23] = 8'h7F;
    endcase
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er;
    logic [4:0]  ef;
    int          elat, lat;
    logic        seen;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00000, 28};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b00101, 1};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b00010, 1};
    vecs[4]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 5'b10100, 28};
    vecs[5]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 5'b01000, 28};
    vecs[6]  = '{32'hBF800000, 32'h7F800000, 32'h80000000, 5'b00000, 1};
    vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00100, 1};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00010, 1};
    vecs[9]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28};
    vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1};
    vecs[11] = '{32'h3F800000, 32'h00000005, 32'h7F800000, 5'b00101, 1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    #1;
    ctx = "reset";
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_flags", 32'(dut_flags()), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].lat, i % 3, "vec");

    // Result held in DONE while out_ready is low; in_valid ignored there
    ctx = "hold";
    bus.a        = 32'h40C00000;
    bus.b        = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("hold_latency", lat, 28);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk); #1;
      check("hold_result", bus.result, 32'h40400000);
      check("hold_flags", 32'(dut_flags()), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.a         = 32'h3F800000;
    bus.b         = 32'h40400000;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00000, 28, 0, "back_to_back");

    // Reset at DIV step 10, asserted together with in_valid
    ctx = "rst_div";
    bus.a        = 32'h40C00000;
    bus.b        = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 32'h3F800000;
    bus.b        = 32'h00000000;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_div_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_div_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_div_result", bus.result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    check("rst_div_no_result", 32'(seen), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 0, "after_rst");

    // Reset in DONE beats a simultaneous out_ready
    ctx = "rst_done";
    bus.a        = 32'h3F800000;
    bus.b        = 32'h00000000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    check("rst_done_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_done_result", bus.result, 32'd0);
    check("rst_done_flags", 32'(dut_flags()), 32'd0);
    check("rst_done_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      model(ra, rb, er, ef, elat);
      run_op(ra, rb, er, ef, elat, int'($urandom_range(0, 3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
